// File: rtl/bt_dir_rx.sv
// bt_dir_rx: UART 8N1 receiver decoding HC-05 command bytes into a held one-hot direction and a pause flag.
// Optional macro BT_CASE_FOLD_EN makes lowercase command letters decode like uppercase.
module bt_dir_rx #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 9600,
    parameter int HOLD_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [3:0] dir,
    output logic       ena,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int DIV      = CLK_HZ / BAUD;
    localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
    localparam int CW       = $clog2(DIV + 1);
    localparam int HW       = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic          meta_q, rxs_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d, rx_byte_q, rx_byte_d, cmd;
    logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
    logic [3:0]    dir_q, dir_d, new_dir;
    logic          ena_q, ena_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            meta_q       <= 1'b1;
            rxs_q        <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            sh_q         <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            dir_q        <= '0;
            ena_q        <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            meta_q       <= rxd;
            rxs_q        <= meta_q;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            sh_q         <= sh_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            dir_q        <= dir_d;
            ena_q        <= ena_d;
            hold_q       <= hold_d;
        end
    end

`ifdef BT_CASE_FOLD_EN
    // Clearing bit 5 maps exactly the six lowercase commands onto their uppercase codes.
    assign cmd = sh_q & 8'hDF;
`else
    assign cmd = sh_q;
`endif

    assign tick    = cnt_q == '0;
    assign new_dir = (cmd == 8'h4C) ? 4'b1000 :
                     (cmd == 8'h52) ? 4'b0001 :
                     (cmd == 8'h55) ? 4'b0100 :
                     (cmd == 8'h44) ? 4'b0010 : 4'b0000;

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? cnt_q : cnt_q - CW'(1);
        bit_d        = bit_q;
        sh_d         = sh_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        dir_d        = dir_q;
        ena_d        = ena_q;
        hold_d       = hold_q;
        if (dir_q != '0) begin
            if (hold_q == '0) dir_d = '0;
            else hold_d = hold_q - HW'(1);
        end
        // A decoded byte below overrides the timer update, so a reload beats a same-cycle expiry.
        case (state_q)
            IDLE: if (!rxs_q) begin
                state_d = START;
                cnt_d   = CW'(DIV / 2 - 1);
            end
            START: if (tick) begin
                state_d = rxs_q ? IDLE : DATA;
                cnt_d   = CW'(DIV - 1);
                bit_d   = '0;
            end
            DATA: if (tick) begin
                sh_d    = {rxs_q, sh_q[7:1]};
                cnt_d   = CW'(DIV - 1);
                bit_d   = bit_q + 3'(1);
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_d = rxs_q ? IDLE : WAIT_IDLE;
                frame_err_d = !rxs_q;
                if (rxs_q) begin
                    rx_byte_d    = sh_q;
                    byte_valid_d = 1'b1;
                    if (new_dir != '0) begin
                        dir_d  = new_dir;
                        hold_d = HW'(HOLD_CYC - 1);
                    end else if (cmd == 8'h53) begin
                        dir_d  = '0;
                        hold_d = '0;
                    end else if (cmd == 8'h50) begin
                        ena_d = !ena_q;
                    end
                end
            end
            WAIT_IDLE: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dir        = dir_q;
    assign ena        = ena_q;
    assign rx_byte    = rx_byte_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_bt_dir_rx.sv
// tb_bt_dir_rx: random and directed UART frames; a scoreboard queue feeds a monitor holding a command-level model.
module tb_bt_dir_rx;
    localparam int DIV  = 16;
    localparam int HOLD = 64;

    typedef struct packed {logic err; logic [7:0] b;} exp_t;

    logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1;
    logic [3:0] dir;
    logic       ena, byte_valid, frame_err;
    logic [7:0] rx_byte;

    exp_t       q[$];
    int         n_cmp = 0, n_bad = 0;
    longint     cyc = 0, t_set = 0;
    logic [3:0] m_dir = '0;
    logic       m_ena = 1'b0;
    logic [7:0] m_byte = '0;
    logic [7:0] cmds[12] = '{8'h4C, 8'h52, 8'h55, 8'h44, 8'h53, 8'h50,
                             8'h6C, 8'h72, 8'h75, 8'h64, 8'h73, 8'h70};

    bt_dir_rx #(.CLK_HZ(16000), .BAUD(1000), .HOLD_MS(4)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .dir(dir), .ena(ena),
        .rx_byte(rx_byte), .byte_valid(byte_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: commands applied at decode; direction lives for HOLD cycles after its last set.
    task automatic apply(input logic [7:0] b);
        logic [7:0] c;
        c = b;
`ifdef BT_CASE_FOLD_EN
        if (c >= "a" && c <= "z") c = c - 8'd32;
`endif
        case (c)
            "L": begin m_dir = 4'b1000; t_set = cyc; end
            "R": begin m_dir = 4'b0001; t_set = cyc; end
            "U": begin m_dir = 4'b0100; t_set = cyc; end
            "D": begin m_dir = 4'b0010; t_set = cyc; end
            "S": m_dir = '0;
            "P": m_ena = !m_ena;
            default: ;
        endcase
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        #2;
        cyc++;
        if (rst) begin
            m_dir = '0; m_ena = 1'b0; m_byte = '0;
            q.delete();
            check("reset_outputs", {17'd0, dir, ena, rx_byte, byte_valid, frame_err}, 32'd0);
        end else begin
            if (byte_valid || frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, byte_valid, frame_err}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", {30'd0, byte_valid, frame_err}, e.err ? 32'd1 : 32'd2);
                    if (!e.err) begin
                        m_byte = e.b;
                        apply(e.b);
                    end
                    check("rx_byte", {24'd0, rx_byte}, {24'd0, m_byte});
                end
            end
            check("dir", {28'd0, dir}, (m_dir != 0 && cyc - t_set < HOLD) ? {28'd0, m_dir} : 32'd0);
            check("ena", {31'd0, ena}, {31'd0, m_ena});
        end
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        q.push_back({!stop, b});
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    initial begin
        int t;
        logic [7:0] b;
        logic err;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(20);
        send("L", 1'b1);
        idle(100);
        send("R", 1'b1); send("R", 1'b1); send("R", 1'b1);
        idle(100);
        send("U", 1'b1); send("S", 1'b1); send("P", 1'b1); send("P", 1'b1);
        idle(20);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        send("D", 1'b1);
        idle(20);
        send(8'h52, 1'b0);
        rxd = 1'b0;
        repeat (30 * DIV) @(negedge clk);
        idle(40);
        send("L", 1'b1);
        idle(20);
        send(8'h6C, 1'b1);
        idle(100);
        send("P", 1'b1); send("U", 1'b1);
        rxd = 1'b0;
        repeat (5 * DIV) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        rst = 1'b0;
        idle(40);
        for (int i = 0; i < 40; i++) begin
            b   = ($urandom_range(0, 12) < 12) ? cmds[$urandom_range(0, 11)] : 8'($urandom);
            err = $urandom_range(0, 7) == 0;
            send(b, !err);
            idle(err ? $urandom_range(20, 40) : ($urandom_range(0, 3) == 0 ? $urandom_range(0, 120) : 0));
        end
        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        idle(100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
